// File: rtl/fpadd_pipe_pkg.sv
// Shared constants, helpers and the operand class type for the parametrised FP adder.
package fp_pkg;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_cls_t;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_exp_ones(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Canonical quiet NaN: +, exp all-ones, only the mantissa MSB set.
  function automatic logic [31:0] fp_canon_nan(input int exp_w, input int man_w);
    return 32'((fp_exp_ones(exp_w) << man_w) | (1 << (man_w - 1)));
  endfunction

endpackage

// File: rtl/fpadd_pipe_if.sv
// Operand/result handshake bundle for fpadd_pipe; master = producer/consumer side.
interface fpadd_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = fp_width(EXP_W, MAN_W);

  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_a;
  logic [W-1:0] i_b;
  logic         i_sub;
  logic         o_valid;
  logic         o_ready;
  logic [W-1:0] o_res;
  logic [3:0]   o_flags;

  modport master (
    output i_valid, i_a, i_b, i_sub, o_ready,
    input  i_ready, o_valid, o_res, o_flags
  );

  modport slave (
    input  i_valid, i_a, i_b, i_sub, o_ready,
    output i_ready, o_valid, o_res, o_flags
  );

endinterface

// File: rtl/fpadd_pipe_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 14,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++)
      if (din[i]) cnt = CW'(WIDTH - 1 - i);
  end

endmodule

// File: rtl/fpadd_pipe.sv
// Three-stage FP add/sub (align | add | normalise+round+pack) with RNE rounding,
// zero/inf/NaN handling and a single global stall driven by the result handshake.
module fpadd_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input logic         clk,
  input logic         rst,
  fpadd_pipe_if.slave bus
);

  localparam int W      = fp_width(EXP_W, MAN_W);
  localparam int MW     = MAN_W + 4;           // hidden + mantissa + G/R/S
  localparam int EW     = EXP_W + 6;           // signed headroom for exp - lzc
  localparam int LZW    = $clog2(MW + 1);
  localparam int STAGES = 3;

  localparam logic [31:0]        NAN32   = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]       QNAN    = NAN32[W-1:0];
  localparam int                 EONES_I = fp_exp_ones(EXP_W);
  localparam logic [EXP_W-1:0]   EONES   = EONES_I[EXP_W-1:0];
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic signed [EW-1:0] E_MAX  = $signed({{(EW-EXP_W){1'b0}}, EONES});

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    mx;
    logic [MW-1:0]    my;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW:0]      sum;
  } s2_t;

  function automatic fp_cls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)         return ZERO;
    else if (e == EONES) return (f == '0) ? INF : NAN;
    else                 return NORM;
  endfunction

  logic [STAGES:1] vld_pipe;
  logic            en;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    res_d, res_q;
  logic [3:0]      flg_d, flg_q;

  assign en          = !vld_pipe[STAGES] | bus.o_ready;
  assign bus.i_ready = en;
  assign bus.o_valid = vld_pipe[STAGES];
  assign bus.o_res   = res_q;
  assign bus.o_flags = flg_q;

  // ---------------- S1: classify, swap, align ----------------
  logic             sa, sb, swap, inf_inf;
  logic [EXP_W-1:0] ea, eb, e_big, e_sml;
  logic [MAN_W-1:0] fa, fb, f_big, f_sml;
  fp_cls_t          ca, cb;
  logic [2*MW-1:0]  wide;
  int               dsh;

  always_comb begin
    sa    = bus.i_a[W-1];
    sb    = bus.i_b[W-1] ^ bus.i_sub;
    ea    = bus.i_a[W-2 -: EXP_W];
    eb    = bus.i_b[W-2 -: EXP_W];
    // Denormals flush to zero: their mantissa never reaches the datapath.
    fa    = (ea == '0) ? '0 : bus.i_a[MAN_W-1:0];
    fb    = (eb == '0) ? '0 : bus.i_b[MAN_W-1:0];
    ca    = classify(ea, bus.i_a[MAN_W-1:0]);
    cb    = classify(eb, bus.i_b[MAN_W-1:0]);
    swap  = {eb, fb} > {ea, fa};
    e_big = swap ? eb : ea;
    f_big = swap ? fb : fa;
    e_sml = swap ? ea : eb;
    f_sml = swap ? fa : fb;
    dsh   = int'(e_big - e_sml);
    if (dsh > MW) dsh = MW;
    // Lower half catches every bit shifted out; it folds into sticky.
    wide  = {(e_sml != '0), f_sml, 3'b000, {MW{1'b0}}} >> dsh;

    s1_d         = '0;
    s1_d.sign    = swap ? sb : sa;
    s1_d.eff_sub = sa ^ sb;
    s1_d.exp     = e_big;
    s1_d.mx      = {(e_big != '0), f_big, 3'b000};
    s1_d.my      = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};

    inf_inf = (ca == INF) && (cb == INF) && (sa != sb);
    if (ca == NAN || cb == NAN || inf_inf) begin
      s1_d.spec              = 1'b1;
      s1_d.spec_res          = QNAN;
      s1_d.spec_flg[FLG_INV] = inf_inf;
    end else if (ca == INF || cb == INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {((ca == INF) ? sa : sb), EONES, {MAN_W{1'b0}}};
    end else if (ca == ZERO && cb == ZERO) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sa & sb, {(W-1){1'b0}}};
    end
  end

  // ---------------- S2: magnitude add/sub ----------------
  always_comb begin
    s2_d          = '0;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.spec_flg = s1_q.spec_flg;
    s2_d.sign     = s1_q.sign;
    s2_d.exp      = s1_q.exp;
    // |mx| >= |my| after the swap, so the difference never goes negative.
    s2_d.sum      = s1_q.eff_sub ? ({1'b0, s1_q.mx} - {1'b0, s1_q.my})
                                 : ({1'b0, s1_q.mx} + {1'b0, s1_q.my});
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]        lz;
  logic [MW-1:0]         nm;
  logic signed [EW-1:0]  e_base, e_n, e_r;
  logic [MAN_W+1:0]      m_r;
  logic [MAN_W-1:0]      frac;
  logic                  inc, inx;

  fp_lzc #(.WIDTH(MW)) u_lzc (
    .din (s2_q.sum[MW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    e_base = $signed({{(EW-EXP_W){1'b0}}, s2_q.exp});
    if (s2_q.sum[MW]) begin
      nm    = s2_q.sum[MW:1];
      nm[0] = s2_q.sum[1] | s2_q.sum[0];
      e_n   = e_base + EW'(1);
    end else begin
      nm    = s2_q.sum[MW-1:0] << lz;
      e_n   = e_base - $signed(EW'(lz));
    end
    inx  = nm[2] | nm[1] | nm[0];
    inc  = nm[2] & (nm[1] | nm[0] | nm[3]);
    m_r  = {1'b0, nm[MW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    // Rounding carry-out renormalises to 1.000..0 with exp + 1.
    e_r  = e_n + $signed(EW'(m_r[MAN_W+1]));
    frac = m_r[MAN_W+1] ? m_r[MAN_W:1] : m_r[MAN_W-1:0];

    res_d = '0;
    flg_d = '0;
    if (s2_q.spec) begin
      res_d = s2_q.spec_res;
      flg_d = s2_q.spec_flg;
    end else if (s2_q.sum == '0) begin
      res_d = '0;
    end else if (e_r >= E_MAX) begin
      res_d          = {s2_q.sign, EONES, {MAN_W{1'b0}}};
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else if (e_r <= E_ZERO) begin
      res_d          = {s2_q.sign, {(W-1){1'b0}}};
      flg_d[FLG_UNF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else begin
      res_d          = {s2_q.sign, e_r[EXP_W-1:0], frac};
      flg_d[FLG_INX] = inx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      res_q    <= '0;
      flg_q    <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.i_valid};
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
    end
  end

endmodule
